// File: rtl/reorder_buffer.sv
// In-order retirement buffer for a dual-issue core: allocates up to two renamed
// instructions per cycle, marks them done on writeback, retires up to two from the head.
module reorder_buffer #(
  parameter int DEPTH = 16,
  parameter int NPREG = 64,
  localparam int TW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid_1,
  input  logic             alloc_valid_2,
  input  logic             alloc_has_rd_1,
  input  logic             alloc_has_rd_2,
  input  logic [4:0]       alloc_rd_1,
  input  logic [4:0]       alloc_rd_2,
  input  logic [5:0]       alloc_newrd_1,
  input  logic [5:0]       alloc_newrd_2,
  input  logic [5:0]       alloc_oldrd_1,
  input  logic [5:0]       alloc_oldrd_2,
  output logic             alloc_ready,
  output logic [TW-1:0]    alloc_tag_1,
  output logic [TW-1:0]    alloc_tag_2,
  input  logic             wb_valid_1,
  input  logic             wb_valid_2,
  input  logic [TW-1:0]    wb_tag_1,
  input  logic [TW-1:0]    wb_tag_2,
  output logic             retire_valid_1,
  output logic             retire_valid_2,
  output logic [4:0]       retire_rd_1,
  output logic [4:0]       retire_rd_2,
  output logic [5:0]       retire_prd_1,
  output logic [5:0]       retire_prd_2,
  output logic [NPREG-1:0] free_regs,
  output logic [TW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [DEPTH-1:0] valid_q, done_q, has_rd_q;
  logic [DEPTH-1:0] valid_d, done_d;
  logic [4:0]       rd_q    [DEPTH];
  logic [5:0]       newrd_q [DEPTH];
  logic [5:0]       oldrd_q [DEPTH];
  logic [TW-1:0]    head_q, tail_q, head_nx1, tail_nx1;
  logic [TW:0]      count_q;
  logic             do_alloc1, do_alloc2, ret1, ret2;
  logic [1:0]       n_alloc, n_ret;

  logic             ret_vld1_p1, ret_vld2_p1;
  logic [4:0]       ret_rd1_p1, ret_rd2_p1;
  logic [5:0]       ret_prd1_p1, ret_prd2_p1;
  logic [NPREG-1:0] free_p1;

  // One-hot free mask; architectural x0 mappings and stores never free a register.
  function automatic logic [NPREG-1:0] free_bit(input logic en, input logic has_rd,
                                                input logic [5:0] prd);
    logic [NPREG-1:0] m;
    m = '0;
    if (en && has_rd && (prd != 6'd0) && (int'(prd) < NPREG)) m[prd] = 1'b1;
    return m;
  endfunction

  assign alloc_ready = (count_q <= (TW+1)'(DEPTH-2));
  assign head_nx1    = head_q + TW'(1);
  assign tail_nx1    = tail_q + TW'(1);
  assign alloc_tag_1 = tail_q;
  assign alloc_tag_2 = alloc_valid_1 ? tail_nx1 : tail_q;
  assign do_alloc1   = alloc_ready && alloc_valid_1;
  assign do_alloc2   = alloc_ready && alloc_valid_2;
  assign n_alloc     = {1'b0, do_alloc1} + {1'b0, do_alloc2};

  assign ret1  = valid_q[head_q] && done_q[head_q];
  assign ret2  = ret1 && valid_q[head_nx1] && done_q[head_nx1];
  assign n_ret = {1'b0, ret1} + {1'b0, ret2};

  // Writeback only lands on entries valid before this edge; retire clears after it.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    if (wb_valid_1 && valid_q[wb_tag_1]) done_d[wb_tag_1] = 1'b1;
    if (wb_valid_2 && valid_q[wb_tag_2]) done_d[wb_tag_2] = 1'b1;
    if (ret1) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
    end
    if (ret2) begin
      valid_d[head_nx1] = 1'b0;
      done_d[head_nx1]  = 1'b0;
    end
    if (do_alloc1) begin
      valid_d[alloc_tag_1] = 1'b1;
      done_d[alloc_tag_1]  = 1'b0;
    end
    if (do_alloc2) begin
      valid_d[alloc_tag_2] = 1'b1;
      done_d[alloc_tag_2]  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_alloc1) begin
      has_rd_q[alloc_tag_1] <= alloc_has_rd_1;
      rd_q[alloc_tag_1]     <= alloc_rd_1;
      newrd_q[alloc_tag_1]  <= alloc_newrd_1;
      oldrd_q[alloc_tag_1]  <= alloc_oldrd_1;
    end
    if (do_alloc2) begin
      has_rd_q[alloc_tag_2] <= alloc_has_rd_2;
      rd_q[alloc_tag_2]     <= alloc_rd_2;
      newrd_q[alloc_tag_2]  <= alloc_newrd_2;
      oldrd_q[alloc_tag_2]  <= alloc_oldrd_2;
    end
  end

  // Stage p1: retire results and pointer/count updates registered together.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      done_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ret_vld1_p1 <= 1'b0;
      ret_vld2_p1 <= 1'b0;
      ret_rd1_p1  <= '0;
      ret_rd2_p1  <= '0;
      ret_prd1_p1 <= '0;
      ret_prd2_p1 <= '0;
      free_p1     <= '0;
    end else begin
      valid_q     <= valid_d;
      done_q      <= done_d;
      head_q      <= head_q + TW'(n_ret);
      tail_q      <= tail_q + TW'(n_alloc);
      count_q     <= count_q + (TW+1)'(n_alloc) - (TW+1)'(n_ret);
      ret_vld1_p1 <= ret1;
      ret_vld2_p1 <= ret2;
      ret_rd1_p1  <= ret1 ? rd_q[head_q]      : '0;
      ret_rd2_p1  <= ret2 ? rd_q[head_nx1]    : '0;
      ret_prd1_p1 <= ret1 ? newrd_q[head_q]   : '0;
      ret_prd2_p1 <= ret2 ? newrd_q[head_nx1] : '0;
      free_p1     <= free_bit(ret1, has_rd_q[head_q], oldrd_q[head_q]) |
                     free_bit(ret2, has_rd_q[head_nx1], oldrd_q[head_nx1]);
    end
  end

  assign retire_valid_1 = ret_vld1_p1;
  assign retire_valid_2 = ret_vld2_p1;
  assign retire_rd_1    = ret_rd1_p1;
  assign retire_rd_2    = ret_rd2_p1;
  assign retire_prd_1   = ret_prd1_p1;
  assign retire_prd_2   = ret_prd2_p1;
  assign free_regs      = free_p1;
  assign count          = count_q;
  assign full           = (count_q == (TW+1)'(DEPTH));
  assign empty          = (count_q == '0);

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: table of per-cycle vectors plus corner-case sequences,
// with an in-order scoreboard of allocated entries checked against every retirement.
module tb_reorder_buffer;
  localparam int DEPTH = 16;
  localparam int NPREG = 64;
  localparam int TW    = 4;

  logic clk = 1'b0;
  logic rst;
  logic alloc_valid_1, alloc_valid_2, alloc_has_rd_1, alloc_has_rd_2;
  logic [4:0] alloc_rd_1, alloc_rd_2;
  logic [5:0] alloc_newrd_1, alloc_newrd_2, alloc_oldrd_1, alloc_oldrd_2;
  logic alloc_ready;
  logic [TW-1:0] alloc_tag_1, alloc_tag_2;
  logic wb_valid_1, wb_valid_2;
  logic [TW-1:0] wb_tag_1, wb_tag_2;
  logic retire_valid_1, retire_valid_2;
  logic [4:0] retire_rd_1, retire_rd_2;
  logic [5:0] retire_prd_1, retire_prd_2;
  logic [NPREG-1:0] free_regs;
  logic [TW:0] count;
  logic full, empty;

  reorder_buffer #(.DEPTH(DEPTH), .NPREG(NPREG)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid_1(alloc_valid_1), .alloc_valid_2(alloc_valid_2),
    .alloc_has_rd_1(alloc_has_rd_1), .alloc_has_rd_2(alloc_has_rd_2),
    .alloc_rd_1(alloc_rd_1), .alloc_rd_2(alloc_rd_2),
    .alloc_newrd_1(alloc_newrd_1), .alloc_newrd_2(alloc_newrd_2),
    .alloc_oldrd_1(alloc_oldrd_1), .alloc_oldrd_2(alloc_oldrd_2),
    .alloc_ready(alloc_ready), .alloc_tag_1(alloc_tag_1), .alloc_tag_2(alloc_tag_2),
    .wb_valid_1(wb_valid_1), .wb_valid_2(wb_valid_2),
    .wb_tag_1(wb_tag_1), .wb_tag_2(wb_tag_2),
    .retire_valid_1(retire_valid_1), .retire_valid_2(retire_valid_2),
    .retire_rd_1(retire_rd_1), .retire_rd_2(retire_rd_2),
    .retire_prd_1(retire_prd_1), .retire_prd_2(retire_prd_2),
    .free_regs(free_regs), .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tag;
    logic       has;
    logic [4:0] rd;
    logic [5:0] prd;
    logic [5:0] old;
    logic       done;
  } rob_e_t;

  typedef struct {
    bit a1, a2, w1;
    int t1;
    bit w2;
    int t2;
    int ecnt;
    bit er1, er2;
  } vec_t;

  rob_e_t     q[$];
  vec_t       tbl[16];
  logic [3:0] mtail;
  int         seq;
  int         ncmp;
  int         nfail;
  bit         use_man;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    ncmp++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  task automatic retire_slot(input string nm, input logic v, input logic [4:0] rd,
                             input logic [5:0] prd, inout logic [63:0] fexp);
    rob_e_t e;
    if (v) begin
      if (q.size() == 0) begin
        chk({nm, "_unexpected"}, 1, 0);
      end else begin
        e = q.pop_front();
        chk({nm, "_rd"}, rd, e.rd);
        chk({nm, "_prd"}, prd, e.prd);
        chk({nm, "_was_done"}, e.done, 1);
        if (e.has && e.old != 6'd0) fexp[e.old] = 1'b1;
      end
    end else begin
      chk({nm, "_idle_fields"}, {rd, prd}, 0);
    end
  endtask

  // One clock cycle: drive, check tags before the edge, check outputs #1 after it.
  task automatic cyc(input bit r, input bit v1, input bit v2, input bit w1, input int t1,
                     input bit w2, input int t2);
    bit acc;
    int s2;
    logic [3:0] tg1, tg2;
    logic [63:0] fexp;
    rob_e_t e;
    rst = r; alloc_valid_1 = v1; alloc_valid_2 = v2;
    wb_valid_1 = w1; wb_tag_1 = 4'(t1); wb_valid_2 = w2; wb_tag_2 = 4'(t2);
    if (!use_man) begin
      s2 = v1 ? seq + 1 : seq;
      alloc_has_rd_1 = 1'b1; alloc_has_rd_2 = 1'b1;
      alloc_rd_1 = 5'((seq % 31) + 1);  alloc_oldrd_1 = 6'((seq % 31) + 1);
      alloc_newrd_1 = 6'(32 + seq % 32);
      alloc_rd_2 = 5'((s2 % 31) + 1);   alloc_oldrd_2 = 6'((s2 % 31) + 1);
      alloc_newrd_2 = 6'(32 + s2 % 32);
    end
    acc = !r && (q.size() <= DEPTH - 2);
    tg1 = mtail;
    tg2 = v1 ? mtail + 4'd1 : mtail;
    #1;
    if (!r) begin
      if (v1) chk("alloc_tag_1", alloc_tag_1, tg1);
      if (v2) chk("alloc_tag_2", alloc_tag_2, tg2);
    end
    @(posedge clk);
    #1;
    fexp = '0;
    if (r) begin
      q.delete();
      mtail = '0;
      chk("rst_retire_valid", {retire_valid_1, retire_valid_2}, 0);
      chk("rst_retire_fields", {retire_rd_1, retire_prd_1, retire_rd_2, retire_prd_2}, 0);
    end else begin
      if (retire_valid_2) chk("retire2_without_1", retire_valid_1, 1);
      retire_slot("retire1", retire_valid_1, retire_rd_1, retire_prd_1, fexp);
      retire_slot("retire2", retire_valid_2, retire_rd_2, retire_prd_2, fexp);
      for (int i = 0; i < q.size(); i++)
        if ((w1 && q[i].tag == 4'(t1)) || (w2 && q[i].tag == 4'(t2))) q[i].done = 1'b1;
      if (acc && v1) begin
        e = '{tag: mtail, has: alloc_has_rd_1, rd: alloc_rd_1, prd: alloc_newrd_1,
              old: alloc_oldrd_1, done: 1'b0};
        q.push_back(e);
        mtail = mtail + 4'd1;
      end
      if (acc && v2) begin
        e = '{tag: mtail, has: alloc_has_rd_2, rd: alloc_rd_2, prd: alloc_newrd_2,
              old: alloc_oldrd_2, done: 1'b0};
        q.push_back(e);
        mtail = mtail + 4'd1;
      end
      if (acc && !use_man) seq += int'(v1) + int'(v2);
    end
    chk("free_regs", free_regs, fexp);
    chk("count", count, q.size());
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
    chk("alloc_ready", alloc_ready, q.size() <= DEPTH - 2);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() > 0; k++) idle();
    chk("drain_left", q.size(), 0);
  endtask

  task automatic set_row(input int i, input bit a1, input bit a2, input bit w1, input int t1,
                         input bit w2, input int t2, input int c, input bit r1, input bit r2);
    tbl[i] = '{a1: a1, a2: a2, w1: w1, t1: t1, w2: w2, t2: t2, ecnt: c, er1: r1, er2: r2};
  endtask

  initial begin
    ncmp = 0; nfail = 0; seq = 0; mtail = '0; use_man = 0;
    rst = 1'b1; alloc_valid_1 = 0; alloc_valid_2 = 0; wb_valid_1 = 0; wb_valid_2 = 0;
    wb_tag_1 = '0; wb_tag_2 = '0;
    alloc_has_rd_1 = 0; alloc_has_rd_2 = 0; alloc_rd_1 = '0; alloc_rd_2 = '0;
    alloc_newrd_1 = '0; alloc_newrd_2 = '0; alloc_oldrd_1 = '0; alloc_oldrd_2 = '0;

    //          a1 a2 w1 t1 w2 t2 cnt r1 r2
    set_row(0,  1, 1, 0, 0, 0, 0, 2, 0, 0);
    set_row(1,  0, 0, 1, 1, 0, 0, 2, 0, 0);
    set_row(2,  0, 0, 0, 0, 0, 0, 2, 0, 0);
    set_row(3,  0, 0, 1, 0, 0, 0, 2, 0, 0);
    set_row(4,  0, 0, 0, 0, 0, 0, 0, 1, 1);
    set_row(5,  0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_row(6,  0, 1, 0, 0, 0, 0, 1, 0, 0);
    set_row(7,  1, 1, 1, 2, 0, 0, 3, 0, 0);
    set_row(8,  0, 0, 1, 4, 1, 3, 2, 1, 0);
    set_row(9,  0, 0, 0, 0, 0, 0, 0, 1, 1);
    set_row(10, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_row(11, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    set_row(12, 1, 0, 1, 5, 0, 0, 1, 0, 0);
    set_row(13, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    set_row(14, 0, 0, 1, 5, 1, 5, 1, 0, 0);
    set_row(15, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      cyc(0, tbl[i].a1, tbl[i].a2, tbl[i].w1, tbl[i].t1, tbl[i].w2, tbl[i].t2);
      chk($sformatf("vec%0d_count", i), count, tbl[i].ecnt);
      chk($sformatf("vec%0d_retire", i), {retire_valid_1, retire_valid_2},
          {tbl[i].er1, tbl[i].er2});
    end

    // Fill to full, then offered allocations must be ignored.
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 1, 0, 0, 0, 0);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    chk("full_ignore_count", count, 16);
    cyc(0, 0, 0, 1, 0, 0, 0);
    idle();
    chk("cnt15_count", count, 15);
    chk("cnt15_ready", alloc_ready, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("cnt15_ignore", count, 15);
    for (int t = 1; t < 16; t += 2) cyc(0, 0, 0, 1, t, 1, (t + 1) % 16);
    drain();

    // Move head/tail to 14, then allocate across the wrap and retire in order.
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 1, 1, 0, 0, 0, 0);
    for (int t = 0; t < 14; t += 2) cyc(0, 0, 0, 1, t, 1, t + 1);
    drain();
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 1, 0);
    idle();
    chk("wrap_hold", {retire_valid_1, retire_valid_2}, 0);
    cyc(0, 0, 0, 1, 15, 1, 14);
    idle();
    chk("wrap_retire_hi", {retire_valid_1, retire_valid_2}, 2'b11);
    idle();
    chk("wrap_retire_lo", {retire_valid_1, retire_valid_2}, 2'b11);
    drain();

    // Dual allocate and dual retire in the same cycle at count 10.
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 1, 1);
    cyc(0, 1, 1, 0, 0, 0, 0);
    chk("c10_count", count, 10);
    chk("c10_retire", {retire_valid_1, retire_valid_2}, 2'b11);
    for (int t = 2; t < 12; t += 2) cyc(0, 0, 0, 1, t, 1, t + 1);
    drain();

    // Store without destination and an entry whose old mapping is register 0.
    cyc(1, 0, 0, 0, 0, 0, 0);
    use_man = 1;
    alloc_has_rd_1 = 0; alloc_rd_1 = 5'd5; alloc_newrd_1 = 6'd40; alloc_oldrd_1 = 6'd7;
    alloc_has_rd_2 = 1; alloc_rd_2 = 5'd3; alloc_newrd_2 = 6'd41; alloc_oldrd_2 = 6'd0;
    cyc(0, 1, 1, 0, 0, 0, 0);
    use_man = 0;
    cyc(0, 0, 0, 1, 0, 1, 1);
    idle();
    chk("nofree_retire", {retire_valid_1, retire_valid_2}, 2'b11);
    chk("nofree_mask", free_regs, 0);

    // Reset with five entries in flight and writeback asserted.
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("flight_count", count, 5);
    cyc(0, 0, 0, 1, 0, 1, 1);
    cyc(1, 1, 1, 1, 2, 1, 3);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_empty", empty, 1);
    chk("rst_mid_free", free_regs, 0);
    idle();
    chk("rst_mid_no_retire", {retire_valid_1, retire_valid_2}, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("rst_mid_realloc", count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
